// File: rtl/grade_blocos.sv
// Breakout brick wall: LINHAS x COLUNAS bitmap checked against the ball once per frame.
// A struck brick is cleared and reported as a one-cycle hit/bounce pulse.
module grade_blocos #(
    parameter int unsigned LINHAS     = 5,
    parameter int unsigned COLUNAS    = 10,
    parameter int unsigned BLK_W_LOG2 = 6,
    parameter int unsigned BLK_H_LOG2 = 4,
    parameter int unsigned TOP_Y      = 32,
    localparam int unsigned NB        = LINHAS * COLUNAS,
    localparam int unsigned CW        = $clog2(NB + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          new_game,
    input  logic          frame_tick,
    input  logic [9:0]    ball_x,
    input  logic [9:0]    ball_y,
    output logic          hit_block,
    output logic          bounce_y,
    output logic [CW-1:0] hit_index,
    output logic [CW-1:0] blocks_left,
    output logic          all_cleared,
    output logic [NB-1:0] block_map
);

    typedef enum logic [1:0] {StOcioso, StCalcula, StVerifica} state_e;

    localparam logic [10:0] YLo = 11'(TOP_Y);
    localparam logic [10:0] YHi = 11'(TOP_Y + (LINHAS << BLK_H_LOG2));
    localparam logic [10:0] XHi = 11'(COLUNAS << BLK_W_LOG2);

    state_e state_q, state_d;

    logic [9:0]    ball_x_q, ball_y_q;
    logic          in_grid_q;
    logic [CW-1:0] idx_q;

    logic [9:0] dy_c, row_c, col_c, idx_c;
    logic       in_grid_c;

    always_comb begin
        dy_c  = ball_y_q - 10'(TOP_Y);
        row_c = dy_c >> BLK_H_LOG2;
        col_c = ball_x_q >> BLK_W_LOG2;
        idx_c = row_c * 10'(COLUNAS) + col_c;
        // widened compares avoid wrap; the idx bound is implied but keeps the index in range
        in_grid_c = ({1'b0, ball_y_q} >= YLo) && ({1'b0, ball_y_q} < YHi) &&
                    ({1'b0, ball_x_q} < XHi) && (idx_c < 10'(NB));
    end

    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = StOcioso;
        end else begin
            case (state_q)
                StOcioso:   if (frame_tick) state_d = StCalcula;
                StCalcula:  state_d = StVerifica;
                StVerifica: state_d = StOcioso;
                default:    state_d = StOcioso;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= StOcioso;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            block_map   <= {NB{1'b1}};
            blocks_left <= CW'(NB);
            hit_block   <= 1'b0;
            bounce_y    <= 1'b0;
            hit_index   <= '0;
            all_cleared <= 1'b0;
            ball_x_q    <= '0;
            ball_y_q    <= '0;
            in_grid_q   <= 1'b0;
            idx_q       <= '0;
        end else if (new_game) begin
            block_map   <= {NB{1'b1}};
            blocks_left <= CW'(NB);
            hit_block   <= 1'b0;
            bounce_y    <= 1'b0;
            all_cleared <= 1'b0;
        end else begin
            hit_block   <= 1'b0;
            bounce_y    <= 1'b0;
            all_cleared <= (blocks_left == '0);
            case (state_q)
                StOcioso: begin
                    if (frame_tick) begin
                        ball_x_q <= ball_x;
                        ball_y_q <= ball_y;
                    end
                end
                StCalcula: begin
                    in_grid_q <= in_grid_c;
                    idx_q     <= idx_c[CW-1:0];
                end
                StVerifica: begin
                    if (in_grid_q && block_map[idx_q]) begin
                        block_map[idx_q] <= 1'b0;
                        blocks_left      <= blocks_left - 1'b1;
                        hit_index        <= idx_q;
                        hit_block        <= 1'b1;
                        bounce_y         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grade_blocos.sv
// Directed bench for grade_blocos: hit detection, misses, full sweep, new_game and reset.
module tb_grade_blocos;

    logic        clock = 1'b0;
    logic        reset, new_game, frame_tick;
    logic [9:0]  ball_x, ball_y;
    logic        hit_block, bounce_y, all_cleared;
    logic [5:0]  hit_index, blocks_left;
    logic [49:0] block_map;

    int n_cmp = 0;
    int n_err = 0;

    logic [49:0] all_ones;

    grade_blocos dut (
        .clock      (clock),
        .reset      (reset),
        .new_game   (new_game),
        .frame_tick (frame_tick),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .hit_block  (hit_block),
        .bounce_y   (bounce_y),
        .hit_index  (hit_index),
        .blocks_left(blocks_left),
        .all_cleared(all_cleared),
        .block_map  (block_map)
    );

    always #5 clock = ~clock;

    // Called at posedge+1. Pulses frame_tick on E0 and watches through E3.
    task automatic send_tick(input logic [9:0] x, input logic [9:0] y,
                             output logic hit_at, output logic bnc_at, output logic stray);
        frame_tick = 1'b1;
        ball_x = x;
        ball_y = y;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        stray = hit_block;
        @(posedge clock); #1;
        stray = stray | hit_block;
        @(posedge clock); #1;
        hit_at = hit_block;
        bnc_at = bounce_y;
        @(posedge clock); #1;
        stray = stray | hit_block;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (block_map !== all_ones) begin n_err++;
            $display("FAIL reset_map got %h want %h", block_map, all_ones); end
        n_cmp++; if (blocks_left !== 6'd50) begin n_err++;
            $display("FAIL reset_left got %0d want 50", blocks_left); end
        n_cmp++; if (hit_block !== 1'b0 || bounce_y !== 1'b0) begin n_err++;
            $display("FAIL reset_pulse got %b%b want 00", hit_block, bounce_y); end
        n_cmp++; if (hit_index !== 6'd0 || all_cleared !== 1'b0) begin n_err++;
            $display("FAIL reset_idx_clr got %0d/%b want 0/0", hit_index, all_cleared); end
    endtask

    task automatic test_first_hit();
        logic h, b, s;
        send_tick(10'd130, 10'd40, h, b, s);
        n_cmp++; if (h !== 1'b1 || b !== 1'b1) begin n_err++;
            $display("FAIL hit1_pulse got %b%b want 11", h, b); end
        n_cmp++; if (s !== 1'b0) begin n_err++;
            $display("FAIL hit1_width got stray=%b want 0", s); end
        n_cmp++; if (hit_index !== 6'd2) begin n_err++;
            $display("FAIL hit1_idx got %0d want 2", hit_index); end
        n_cmp++; if (blocks_left !== 6'd49) begin n_err++;
            $display("FAIL hit1_left got %0d want 49", blocks_left); end
        n_cmp++; if (block_map[2] !== 1'b0) begin n_err++;
            $display("FAIL hit1_map got %b want 0", block_map[2]); end
    endtask

    task automatic test_repeat_hit();
        logic h, b, s;
        send_tick(10'd130, 10'd40, h, b, s);
        n_cmp++; if (h !== 1'b0 || s !== 1'b0) begin n_err++;
            $display("FAIL repeat_pulse got %b/%b want 0/0", h, s); end
        n_cmp++; if (blocks_left !== 6'd49) begin n_err++;
            $display("FAIL repeat_left got %0d want 49", blocks_left); end
    endtask

    task automatic test_out_of_grid();
        logic h, b, s;
        logic [9:0] xs [3];
        logic [9:0] ys [3];
        logic [49:0] exp_map;
        xs = '{10'd700, 10'd130, 10'd130};
        ys = '{10'd40,  10'd20,  10'd112};
        exp_map = all_ones;
        exp_map[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_tick(xs[i], ys[i], h, b, s);
            n_cmp++; if (h !== 1'b0 || s !== 1'b0) begin n_err++;
                $display("FAIL miss%0d_pulse got %b/%b want 0/0", i, h, s); end
            n_cmp++; if (block_map !== exp_map) begin n_err++;
                $display("FAIL miss%0d_map got %h want %h", i, block_map, exp_map); end
        end
        n_cmp++; if (blocks_left !== 6'd49) begin n_err++;
            $display("FAIL miss_left got %0d want 49", blocks_left); end
    endtask

    task automatic test_sweep();
        logic h, b, s;
        int pulses;
        pulses = 0;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 10; c++) begin
                send_tick(10'(32 + 64 * c), 10'(40 + 16 * r), h, b, s);
                if (h === 1'b1) pulses++;
                n_cmp++; if (h !== 1'b1 || hit_index !== 6'(r * 10 + c)) begin n_err++;
                    $display("FAIL sweep_r%0dc%0d got hit=%b idx=%0d want 1/%0d",
                             r, c, h, hit_index, r * 10 + c); end
            end
        end
        n_cmp++; if (pulses != 50) begin n_err++;
            $display("FAIL sweep_count got %0d want 50", pulses); end
        n_cmp++; if (blocks_left !== 6'd0 || block_map !== 50'd0) begin n_err++;
            $display("FAIL sweep_left got %0d map %h want 0/0", blocks_left, block_map); end
        n_cmp++; if (all_cleared !== 1'b1) begin n_err++;
            $display("FAIL sweep_cleared got %b want 1", all_cleared); end
        send_tick(10'd32, 10'd40, h, b, s);
        n_cmp++; if (h !== 1'b0 || s !== 1'b0 || blocks_left !== 6'd0) begin n_err++;
            $display("FAIL sweep_extra got %b/%b left=%0d want 0/0/0", h, s, blocks_left); end
        n_cmp++; if (all_cleared !== 1'b1) begin n_err++;
            $display("FAIL sweep_hold got %b want 1", all_cleared); end
    endtask

    task automatic test_new_game_cancel();
        logic seen;
        frame_tick = 1'b1; ball_x = 10'd130; ball_y = 10'd40;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        new_game = 1'b1;
        @(posedge clock); #1;
        new_game = 1'b0;
        seen = hit_block;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            seen = seen | hit_block;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++;
            $display("FAIL ng_cancel got hit=%b want 0", seen); end
        n_cmp++; if (block_map !== all_ones || blocks_left !== 6'd50) begin n_err++;
            $display("FAIL ng_restore got %h/%0d want all ones/50", block_map, blocks_left); end
        n_cmp++; if (all_cleared !== 1'b0) begin n_err++;
            $display("FAIL ng_cleared got %b want 0", all_cleared); end
    endtask

    task automatic test_collide_and_reset();
        logic seen;
        frame_tick = 1'b1; new_game = 1'b1; ball_x = 10'd130; ball_y = 10'd40;
        @(posedge clock); #1;
        frame_tick = 1'b0; new_game = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            seen = seen | hit_block;
        end
        n_cmp++; if (seen !== 1'b0 || blocks_left !== 6'd50) begin n_err++;
            $display("FAIL collide got hit=%b left=%0d want 0/50", seen, blocks_left); end
        // tick at E0, reset asserted for E2 while the FSM sits in the check state
        frame_tick = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_cmp++; if (hit_block !== 1'b0 || bounce_y !== 1'b0) begin n_err++;
            $display("FAIL rst_mid_pulse got %b%b want 00", hit_block, bounce_y); end
        n_cmp++; if (block_map !== all_ones || blocks_left !== 6'd50) begin n_err++;
            $display("FAIL rst_mid_map got %h/%0d want all ones/50", block_map, blocks_left); end
        n_cmp++; if (hit_index !== 6'd0 || all_cleared !== 1'b0) begin n_err++;
            $display("FAIL rst_mid_idx got %0d/%b want 0/0", hit_index, all_cleared); end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            seen = seen | hit_block;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++;
            $display("FAIL rst_mid_late got hit=%b want 0", seen); end
    endtask

    initial begin
        all_ones   = {50{1'b1}};
        reset      = 1'b1;
        new_game   = 1'b0;
        frame_tick = 1'b0;
        ball_x     = '0;
        ball_y     = '0;
        @(posedge clock); #1;
        test_reset();
        test_first_hit();
        test_repeat_hit();
        test_out_of_grid();
        test_sweep();
        test_new_game_cancel();
        test_collide_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
